// File: rtl/video_bg_shifter_pkg.sv
// Sequencer strobe bit indices for the PPU video path, plus small helpers
// shared by the background pixel pipeline.
package video_control_signals;

    localparam int VIDEO_CONTROL_WIDTH = 16;

    // Existing sequencer strobe indices. Bit 0 is owned by the left-8 clip
    // logic; bits 1..9 are reserved for the other fetch and sprite strobes.
    localparam int video_left_most_8  = 0;

    // Background pipeline strobes.
    localparam int video_bg_latch_lo  = 10;
    localparam int video_bg_latch_hi  = 11;
    localparam int video_bg_latch_at  = 12;
    localparam int video_bg_load      = 13;
    localparam int video_bg_shift     = 14;

    // Pick the 2-bit palette field of an attribute byte for one 16x16 quadrant.
    // Quadrant {coarse_y[1], coarse_x[1]} selects bits 2q+1:2q.
    function automatic logic [1:0] attr_quadrant(input logic [7:0] data,
                                                 input logic [1:0] quad);
        return data[{quad, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/video_bg_shifter_shift_pair.sv
// One bit-plane of the background pipeline: a 16-bit pattern shifter, an
// 8-bit attribute shifter with its feed bit, and the registered pixel tap.
module video_bg_shift_pair (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic       load_i,
    input  logic       shift_i,
    input  logic [7:0] tile_i,
    input  logic       attr_bit_i,
    input  logic [2:0] fine_x_i,
    output logic [1:0] pix_o
);

    logic [15:0] pat_q, pat_d;
    logic [7:0]  at_q, at_d;
    logic        at_bit_q, at_bit_d;
    logic [1:0]  pix_q, pix_d;

    // Next state: shift first, then a load overwrites the low pattern byte and
    // the feed bit, so the attribute shifter always takes the old feed bit.
    // 15-fine_x is {1,~fine_x} and 7-fine_x is ~fine_x for a 3-bit fine_x.
    always_comb begin
        pat_d    = pat_q;
        at_d     = at_q;
        at_bit_d = at_bit_q;
        if (shift_i) begin
            pat_d = {pat_q[14:0], 1'b0};
            at_d  = {at_q[6:0], at_bit_q};
        end
        if (load_i) begin
            pat_d[7:0] = tile_i;
            at_bit_d   = attr_bit_i;
        end
        pix_d = {at_q[~fine_x_i], pat_q[{1'b1, ~fine_x_i}]};
    end

    // State advances only on dot-enabled clocks; reset clears everything.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            pat_q    <= '0;
            at_q     <= '0;
            at_bit_q <= 1'b0;
            pix_q    <= '0;
        end else if (enable_i) begin
            pat_q    <= pat_d;
            at_q     <= at_d;
            at_bit_q <= at_bit_d;
            pix_q    <= pix_d;
        end
    end

    assign pix_o = pix_q;

endmodule

// File: rtl/video_bg_shifter.sv
// Background pixel pipeline: latches tile/attribute fetch bytes, feeds the
// lo and hi plane shifters and produces the 4-bit background palette index.
module video_bg_shifter
    import video_control_signals::*;
(
    input  logic        I_clock,
    input  logic        I_reset,
    input  logic        I_dot_clk,
    input  logic [15:0] I_control,
    input  logic [7:0]  I_data,
    input  logic [1:0]  I_quadrant,
    input  logic [2:0]  I_fine_x,
    output logic [3:0]  O_bg_color
);

    logic [7:0] tile_lo_q, tile_lo_d;
    logic [7:0] tile_hi_q, tile_hi_d;
    logic [1:0] attr_latch_q, attr_latch_d;
    logic [1:0] lo_pix, hi_pix;
    logic       ctrl_unused;

    // Only the background strobes matter here; fold the rest away.
    assign ctrl_unused = ^I_control;

    // Fetch latches: each strobe acts on its own latch independently.
    always_comb begin
        tile_lo_d    = tile_lo_q;
        tile_hi_d    = tile_hi_q;
        attr_latch_d = attr_latch_q;
        if (I_control[video_bg_latch_lo]) tile_lo_d    = I_data;
        if (I_control[video_bg_latch_hi]) tile_hi_d    = I_data;
        if (I_control[video_bg_latch_at]) attr_latch_d = attr_quadrant(I_data, I_quadrant);
    end

    // Latch registers; loads in the same dot see these pre-edge values.
    always_ff @(posedge I_clock or posedge I_reset) begin
        if (I_reset) begin
            tile_lo_q    <= '0;
            tile_hi_q    <= '0;
            attr_latch_q <= '0;
        end else if (I_dot_clk) begin
            tile_lo_q    <= tile_lo_d;
            tile_hi_q    <= tile_hi_d;
            attr_latch_q <= attr_latch_d;
        end
    end

    video_bg_shift_pair u_lo (
        .clock_i    (I_clock),
        .reset_i    (I_reset),
        .enable_i   (I_dot_clk),
        .load_i     (I_control[video_bg_load]),
        .shift_i    (I_control[video_bg_shift]),
        .tile_i     (tile_lo_q),
        .attr_bit_i (attr_latch_q[0]),
        .fine_x_i   (I_fine_x),
        .pix_o      (lo_pix)
    );

    video_bg_shift_pair u_hi (
        .clock_i    (I_clock),
        .reset_i    (I_reset),
        .enable_i   (I_dot_clk),
        .load_i     (I_control[video_bg_load]),
        .shift_i    (I_control[video_bg_shift]),
        .tile_i     (tile_hi_q),
        .attr_bit_i (attr_latch_q[1]),
        .fine_x_i   (I_fine_x),
        .pix_o      (hi_pix)
    );

    assign O_bg_color = {hi_pix[1], lo_pix[1], hi_pix[0], lo_pix[0]};

endmodule

// File: tb/tb_video_bg_shifter.sv
// Scoreboard bench for video_bg_shifter: a behavioural model predicts each
// dot's output when stimulus is driven; the DUT output is popped and checked.
module tb_video_bg_shifter;
    import video_control_signals::*;

    logic        I_clock = 1'b0;
    logic        I_reset = 1'b1;
    logic        I_dot_clk = 1'b0;
    logic [15:0] I_control = '0;
    logic [7:0]  I_data = '0;
    logic [1:0]  I_quadrant = '0;
    logic [2:0]  I_fine_x = '0;
    logic [3:0]  O_bg_color;

    int total = 0;
    int bad   = 0;

    localparam logic [15:0] C_LO = 16'(1) << video_bg_latch_lo;
    localparam logic [15:0] C_HI = 16'(1) << video_bg_latch_hi;
    localparam logic [15:0] C_AT = 16'(1) << video_bg_latch_at;
    localparam logic [15:0] C_LD = 16'(1) << video_bg_load;
    localparam logic [15:0] C_SH = 16'(1) << video_bg_shift;

    // Reference model state
    logic [15:0] m_plo = '0, m_phi = '0;
    logic [7:0]  m_alo = '0, m_ahi = '0;
    logic        m_blo = 1'b0, m_bhi = 1'b0;
    logic [7:0]  m_tlo = '0, m_thi = '0;
    logic [1:0]  m_at = '0;
    logic [3:0]  m_out = '0;
    logic [3:0]  exp_q[$];

    video_bg_shifter dut (
        .I_clock    (I_clock),
        .I_reset    (I_reset),
        .I_dot_clk  (I_dot_clk),
        .I_control  (I_control),
        .I_data     (I_data),
        .I_quadrant (I_quadrant),
        .I_fine_x   (I_fine_x),
        .O_bg_color (O_bg_color)
    );

    always #5 I_clock = ~I_clock;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_plo = '0; m_phi = '0; m_alo = '0; m_ahi = '0;
        m_blo = 1'b0; m_bhi = 1'b0; m_tlo = '0; m_thi = '0;
        m_at = '0; m_out = '0;
    endtask

    // Drive one clock of stimulus, predict, then compare after the edge.
    task automatic dot(input string tag, input logic [15:0] ctrl, input logic [7:0] data,
                       input logic [1:0] quad, input logic [2:0] fx, input logic en);
        int s, a;
        logic [15:0] n_plo, n_phi;
        logic [7:0]  n_alo, n_ahi;
        logic        n_blo, n_bhi;
        logic [3:0]  e;
        I_control = ctrl; I_data = data; I_quadrant = quad; I_fine_x = fx; I_dot_clk = en;
        if (en) begin
            s = 15 - int'(fx);
            a = 7 - int'(fx);
            m_out = {m_ahi[a], m_alo[a], m_phi[s], m_plo[s]};
            n_plo = m_plo; n_phi = m_phi; n_alo = m_alo; n_ahi = m_ahi;
            n_blo = m_blo; n_bhi = m_bhi;
            if (ctrl[video_bg_shift]) begin
                n_plo = m_plo << 1;
                n_phi = m_phi << 1;
                n_alo = {m_alo[6:0], m_blo};
                n_ahi = {m_ahi[6:0], m_bhi};
            end
            if (ctrl[video_bg_load]) begin
                n_plo[7:0] = m_tlo;
                n_phi[7:0] = m_thi;
                n_blo = m_at[0];
                n_bhi = m_at[1];
            end
            if (ctrl[video_bg_latch_lo]) m_tlo = data;
            if (ctrl[video_bg_latch_hi]) m_thi = data;
            if (ctrl[video_bg_latch_at]) begin
                case (quad)
                    2'd0: m_at = data[1:0];
                    2'd1: m_at = data[3:2];
                    2'd2: m_at = data[5:4];
                    default: m_at = data[7:6];
                endcase
            end
            m_plo = n_plo; m_phi = n_phi; m_alo = n_alo; m_ahi = n_ahi;
            m_blo = n_blo; m_bhi = n_bhi;
        end
        exp_q.push_back(m_out);
        @(posedge I_clock);
        #1;
        e = exp_q.pop_front();
        check_eq(tag, 16'(O_bg_color), 16'(e));
    endtask

    logic [15:0] collect;

    initial begin
        // Power-up reset: output must already be zero.
        #12;
        check_eq("por_zero", 16'(O_bg_color), 16'h0);
        @(negedge I_clock);
        I_reset = 1'b0;

        // Latch / load / shift walk-through, fine_x = 0.
        dot("tp_lat_lo", C_LO, 8'h80, 2'd0, 3'd0, 1'b1);
        dot("tp_lat_hi", C_HI, 8'h00, 2'd0, 3'd0, 1'b1);
        dot("tp_lat_at", C_AT, 8'hE4, 2'd2, 3'd0, 1'b1);
        dot("tp_load",   C_LD, 8'h00, 2'd0, 3'd0, 1'b1);
        for (int i = 0; i < 8; i++) dot("tp_shift", C_SH, 8'h00, 2'd0, 3'd0, 1'b1);
        dot("tp_out", 16'h0, 8'h00, 2'd0, 3'd0, 1'b1);
        check_eq("tp_1001", 16'(O_bg_color), 16'h9);

        // Quadrant select: one shift brings the feed bits to at[0] (fine_x=7).
        for (int q = 0; q < 4; q++) begin
            dot("qd_lat", C_AT, 8'hE4, 2'(q), 3'd0, 1'b1);
            dot("qd_load", C_LD, 8'h00, 2'd0, 3'd0, 1'b1);
            dot("qd_shift", C_SH, 8'h00, 2'd0, 3'd0, 1'b1);
            dot("qd_out", 16'h0, 8'h00, 2'd0, 3'd7, 1'b1);
            check_eq("qd_attr", 16'(O_bg_color[3:2]), 16'(q));
        end

        // Fine-X sweep on pat_lo=0x0100, pat_hi=0xFF00.
        dot("fx_lat_lo", C_LO, 8'h01, 2'd0, 3'd0, 1'b1);
        dot("fx_lat_hi", C_HI, 8'hFF, 2'd0, 3'd0, 1'b1);
        dot("fx_load",   C_LD, 8'h00, 2'd0, 3'd0, 1'b1);
        for (int i = 0; i < 8; i++) dot("fx_shift", C_SH, 8'h00, 2'd0, 3'd0, 1'b1);
        for (int f = 0; f < 8; f++) begin
            dot("fx_sel", 16'h0, 8'h00, 2'd0, 3'(f), 1'b1);
        end
        for (int f = 0; f < 8; f++) begin
            dot("fx_sweep", 16'h0, 8'h00, 2'd0, 3'(f), 1'b1);
            check_eq("fx_lo_bit", 16'(O_bg_color[0]), (f == 7) ? 16'h1 : 16'h0);
            check_eq("fx_hi_bit", 16'(O_bg_color[1]), 16'h1);
        end

        // Simultaneous shift + load: pat_lo 0xA5C3 with tile 0x3C -> 0x4B3C.
        dot("sl_lat_a5", C_LO, 8'hA5, 2'd0, 3'd0, 1'b1);
        dot("sl_load_a5", C_LD, 8'h00, 2'd0, 3'd0, 1'b1);
        for (int i = 0; i < 8; i++) dot("sl_shift", C_SH, 8'h00, 2'd0, 3'd0, 1'b1);
        dot("sl_lat_c3", C_LO | C_AT, 8'hC3, 2'd0, 3'd0, 1'b1);
        dot("sl_load_c3", C_LD, 8'h00, 2'd0, 3'd0, 1'b1);
        dot("sl_lat_3c", C_LO | C_AT, 8'h3C, 2'd0, 3'd0, 1'b1);
        dot("sl_both", C_SH | C_LD, 8'h00, 2'd0, 3'd0, 1'b1);
        dot("sl_feed", 16'h0, 8'h00, 2'd0, 3'd7, 1'b1);
        check_eq("sl_old_feed", 16'(O_bg_color[3:2]), 16'h3);
        collect = '0;
        for (int i = 0; i < 16; i++) begin
            dot("sl_drain", C_SH, 8'h00, 2'd0, 3'd0, 1'b1);
            collect = {collect[14:0], O_bg_color[0]};
        end
        check_eq("sl_pat_lo", collect, 16'h4B3C);

        // Dot enable low: strobes asserted, nothing may change.
        dot("en_prime", C_LO | C_HI | C_AT, 8'h5A, 2'd1, 3'd0, 1'b1);
        dot("en_prime2", C_LD, 8'h00, 2'd0, 3'd0, 1'b1);
        for (int i = 0; i < 5; i++)
            dot("en_hold", 16'hFFFF, 8'($urandom), 2'($urandom), 3'($urandom), 1'b0);
        for (int i = 0; i < 16; i++) dot("en_after", C_SH, 8'h00, 2'd0, 3'($urandom), 1'b1);

        // Random traffic.
        for (int i = 0; i < 300; i++)
            dot("rnd", 16'($urandom), 8'($urandom), 2'($urandom), 3'($urandom),
                ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0);

        // Asynchronous reset mid-cycle.
        #3;
        I_reset = 1'b1;
        #1;
        check_eq("rst_async", 16'(O_bg_color), 16'h0);
        model_reset();
        @(negedge I_clock);
        I_reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dot("rst_drain", C_SH | C_LD, 8'h00, 2'd0, 3'($urandom), 1'b1);
            check_eq("rst_zero", 16'(O_bg_color), 16'h0);
        end
        for (int i = 0; i < 100; i++)
            dot("rnd2", 16'($urandom), 8'($urandom), 2'($urandom), 3'($urandom), 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
